// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    localparam int DMEM_ADDR_W = 64;
    localparam int DMEM_DATA_W = 64;
    localparam int STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        MEMC_IDLE = 2'd0,
        MEMC_REQ  = 2'd1,
        MEMC_WAIT = 2'd2,
        MEMC_RESP = 2'd3
    } memc_state_e;

    // A new access may start only for a real load/store that is not being flushed.
    function automatic logic is_mem_start(input logic valid, input logic load,
                                          input logic store, input logic flush);
        return valid & (load | store) & ~flush;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_timer.sv
// WAIT-state timeout counter: clears while idle, counts while enabled,
// and flags the last permitted WAIT cycle.
module mem_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Next count: hold at the last value rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: issues one data-memory request per load/store,
// freezes the upstream pipeline while it is in flight, and hands the result
// to MEM/WB with a one-cycle done pulse.
// Optional build macro MEM_STALL_CNT_EN adds a saturating stall-cycle counter;
// without it stall_cnt_o is constant zero.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// MEMC_IDLE | no access; start one when EX/MEM holds an unflushed load/store
// MEMC_REQ  | request valid on the bus, fields held until ready
// MEMC_WAIT | request accepted, waiting for response or timeout
// MEMC_RESP | done pulse, stall released so EX/MEM advances; back to IDLE
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_op_valid_i,
    input  logic                   mem_is_load_i,
    input  logic                   mem_is_store_i,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      mem_wdata_i,
    input  logic [DATA_W/8-1:0]    mem_wmask_i,
    output logic                   dmem_req_valid_o,
    input  logic                   dmem_req_ready_i,
    output logic                   dmem_req_wen_o,
    output logic [ADDR_W-1:0]      dmem_req_addr_o,
    output logic [DATA_W-1:0]      dmem_req_wdata_o,
    output logic [DATA_W/8-1:0]    dmem_req_wmask_o,
    input  logic                   dmem_rsp_valid_i,
    input  logic [DATA_W-1:0]      dmem_rsp_rdata_i,
    input  logic                   dmem_rsp_err_i,
    output logic                   pipe_stall_o,
    output logic                   mem_done_o,
    output logic [DATA_W-1:0]      mem_rdata_o,
    output logic                   mem_err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam int MASK_W = DATA_W / 8;

    memc_state_e       state_q, state_d;
    logic              req_wen_q, req_wen_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [MASK_W-1:0] req_wmask_q, req_wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              start;
    logic              timer_expired;

    assign start = is_mem_start(mem_op_valid_i, mem_is_load_i, mem_is_store_i, flush_i);

    mem_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != MEMC_WAIT),
        .en_i     (state_q == MEMC_WAIT),
        .expired_o(timer_expired)
    );

    // Next state, request field capture, result capture and stall.
    always_comb begin
        state_d      = state_q;
        req_wen_d    = req_wen_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wmask_d  = req_wmask_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        pipe_stall_o = 1'b0;
        case (state_q)
            MEMC_IDLE: begin
                if (start) begin
                    pipe_stall_o = 1'b1;
                    req_wen_d    = mem_is_store_i;
                    req_addr_d   = mem_addr_i;
                    req_wdata_d  = mem_is_store_i ? mem_wdata_i : '0;
                    req_wmask_d  = mem_is_store_i ? mem_wmask_i : '0;
                    state_d      = MEMC_REQ;
                end
            end
            MEMC_REQ: begin
                pipe_stall_o = 1'b1;
                if (dmem_req_ready_i) begin
                    state_d = MEMC_WAIT;
                end
            end
            MEMC_WAIT: begin
                pipe_stall_o = 1'b1;
                // A response in the timeout cycle still counts as a real response.
                if (dmem_rsp_valid_i) begin
                    rdata_d = req_wen_q ? '0 : dmem_rsp_rdata_i;
                    err_d   = dmem_rsp_err_i;
                    state_d = MEMC_RESP;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = MEMC_RESP;
                end
            end
            MEMC_RESP: begin
                // The completed op is still visible on the inputs; never re-accept it here.
                state_d = MEMC_IDLE;
            end
            default: begin
                state_d = MEMC_IDLE;
            end
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MEMC_IDLE;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign dmem_req_valid_o = (state_q == MEMC_REQ);
    assign dmem_req_wen_o   = req_wen_q;
    assign dmem_req_addr_o  = req_addr_q;
    assign dmem_req_wdata_o = req_wdata_q;
    assign dmem_req_wmask_o = req_wmask_q;
    assign mem_done_o       = (state_q == MEMC_RESP);
    assign mem_rdata_o      = rdata_q;
    assign mem_err_o        = err_q;

`ifdef MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (pipe_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_access_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_op_valid_i, mem_is_load_i, mem_is_store_i, flush_i;
    logic [63:0] mem_addr_i, mem_wdata_i;
    logic [7:0]  mem_wmask_i;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_req_wen_o;
    logic [63:0] dmem_req_addr_o, dmem_req_wdata_o;
    logic [7:0]  dmem_req_wmask_o;
    logic        dmem_rsp_valid_i, dmem_rsp_err_i;
    logic [63:0] dmem_rsp_rdata_i;
    logic        pipe_stall_o, mem_done_o, mem_err_o;
    logic [63:0] mem_rdata_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;

    // Reference model: one outstanding transaction described by a few flags.
    bit          m_active;   // access accepted, not yet completed
    bit          m_hs;       // request handshake done
    bit          m_finish;   // completion being reported this cycle
    int          m_waited;
    bit          m_wen;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_wmask;
    bit          m_err;
    longint      m_stall;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .mem_op_valid_i(mem_op_valid_i), .mem_is_load_i(mem_is_load_i),
        .mem_is_store_i(mem_is_store_i), .flush_i(flush_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_req_wen_o(dmem_req_wen_o), .dmem_req_addr_o(dmem_req_addr_o),
        .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_req_wmask_o(dmem_req_wmask_o),
        .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
        .dmem_rsp_err_i(dmem_rsp_err_i), .pipe_stall_o(pipe_stall_o),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_hs = 0; m_finish = 0; m_waited = 0;
        m_rdata = '0; m_err = 0; m_stall = 0;
    endtask

    task automatic model_finish(input logic [63:0] rd, input bit er);
        m_active = 0;
        m_finish = 1;
        m_rdata  = rd;
        m_err    = er;
    endtask

    // Compare this cycle's outputs, then advance the model with this cycle's inputs.
    task automatic model_cycle();
        bit          start_now, e_stall, e_req;
        logic [63:0] e_cnt;
        if (rst) begin
            model_reset();
            return;
        end
        start_now = mem_op_valid_i && (mem_is_load_i || mem_is_store_i) && !flush_i;
        e_req     = m_active && !m_hs;
        e_stall   = m_active || (!m_finish && start_now);
`ifdef MEM_STALL_CNT_EN
        e_cnt = 64'(m_stall);
`else
        e_cnt = 64'd0;
`endif
        chk("stall", pipe_stall_o, e_stall);
        chk("req_valid", dmem_req_valid_o, e_req);
        chk("done", mem_done_o, m_finish);
        chk("rdata", mem_rdata_o, m_rdata);
        chk("err", mem_err_o, m_err);
        chk("stall_cnt", stall_cnt_o, e_cnt);
        if (e_req) begin
            chk("req_wen", dmem_req_wen_o, m_wen);
            chk("req_addr", dmem_req_addr_o, m_addr);
            chk("req_wmask", dmem_req_wmask_o, m_wmask);
            if (m_wen) chk("req_wdata", dmem_req_wdata_o, m_wdata);
            if (dmem_req_ready_i) hs_count++;
        end
        if (e_stall) m_stall++;
        if (m_finish) begin
            m_finish = 0;
        end else if (!m_active) begin
            if (start_now) begin
                m_active = 1;
                m_hs     = 0;
                m_wen    = mem_is_store_i;
                m_addr   = mem_addr_i;
                m_wdata  = mem_wdata_i;
                m_wmask  = mem_is_store_i ? mem_wmask_i : 8'h00;
            end
        end else if (!m_hs) begin
            if (dmem_req_ready_i) begin
                m_hs     = 1;
                m_waited = 0;
            end
        end else begin
            if (dmem_rsp_valid_i) model_finish(m_wen ? 64'd0 : dmem_rsp_rdata_i, dmem_rsp_err_i);
            else if (m_waited == T - 1) model_finish(64'd0, 1'b1);
            else m_waited++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_in();
        mem_op_valid_i = 0; mem_is_load_i = 0; mem_is_store_i = 0; flush_i = 0;
        dmem_req_ready_i = 0; dmem_rsp_valid_i = 0; dmem_rsp_err_i = 0;
    endtask

    task automatic set_load(input logic [63:0] a);
        mem_op_valid_i = 1; mem_is_load_i = 1; mem_is_store_i = 0; mem_addr_i = a;
    endtask

    initial begin
        int done1, req2, kind;
        rst = 1;
        clr_in();
        mem_addr_i = '0; mem_wdata_i = '0; mem_wmask_i = '0; dmem_rsp_rdata_i = '0;
        model_reset();
        step();
        step();
        chk("rst_req_valid", dmem_req_valid_o, 0);
        chk("rst_req_addr", dmem_req_addr_o, 0);
        chk("rst_req_wdata", dmem_req_wdata_o, 0);
        chk("rst_req_wmask", dmem_req_wmask_o, 0);
        chk("rst_req_wen", dmem_req_wen_o, 0);
        chk("rst_done", mem_done_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_err", mem_err_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        rst = 0;
        step();

        // Minimum-latency load.
        set_load(64'h0000_0000_1000_0040);
        step();
        chk("ld_req_valid", dmem_req_valid_o, 1);
        chk("ld_req_addr", dmem_req_addr_o, 64'h0000_0000_1000_0040);
        chk("ld_req_wen", dmem_req_wen_o, 0);
        dmem_req_ready_i = 1;
        step();
        chk("ld_wait_no_req", dmem_req_valid_o, 0);
        dmem_req_ready_i = 0;
        dmem_rsp_valid_i = 1;
        dmem_rsp_rdata_i = 64'hDEAD_BEEF_0123_4567;
        step();
        chk("ld_done", mem_done_o, 1);
        chk("ld_rdata", mem_rdata_o, 64'hDEAD_BEEF_0123_4567);
        chk("ld_err", mem_err_o, 0);
        dmem_rsp_valid_i = 0;
        step();
        chk("ld_done_pulse", mem_done_o, 0);
        chk("ld_no_reaccept", dmem_req_valid_o, 0);
        clr_in();
        step();

        // Store with ready held low; EX/MEM inputs wiggle to prove the fields are latched.
        hs_count = 0;
        mem_op_valid_i = 1; mem_is_store_i = 1;
        mem_addr_i = 64'h0000_0000_8000_0010;
        mem_wdata_i = 64'hCAFE_F00D_5555_AAAA;
        mem_wmask_i = 8'h0F;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("st_req_valid", dmem_req_valid_o, 1);
            chk("st_req_addr", dmem_req_addr_o, 64'h0000_0000_8000_0010);
            chk("st_req_wmask", dmem_req_wmask_o, 8'h0F);
            chk("st_stall", pipe_stall_o, 1);
            mem_addr_i  = {$urandom, $urandom};
            mem_wmask_i = 8'($urandom);
            step();
        end
        dmem_req_ready_i = 1;
        step();
        dmem_req_ready_i = 0;
        dmem_rsp_valid_i = 1;
        dmem_rsp_rdata_i = 64'h1111_2222_3333_4444;
        step();
        chk("st_done", mem_done_o, 1);
        chk("st_rdata_zero", mem_rdata_o, 0);
        clr_in();
        step();
        chk("st_one_handshake", hs_count, 1);

        // Timeout: no response for T WAIT cycles, then late responses are dropped.
        set_load(64'h40);
        step();
        dmem_req_ready_i = 1;
        step();
        dmem_req_ready_i = 0;
        for (int i = 0; i < T; i++) begin
            chk("to_not_done", mem_done_o, 0);
            step();
        end
        chk("to_done", mem_done_o, 1);
        chk("to_err", mem_err_o, 1);
        chk("to_rdata", mem_rdata_o, 0);
        clr_in();
        dmem_rsp_valid_i = 1;
        dmem_rsp_rdata_i = 64'hFFFF_0000_FFFF_0000;
        step();
        chk("to_late_done", mem_done_o, 0);
        step();
        chk("to_late_req", dmem_req_valid_o, 0);
        chk("to_late_rdata", mem_rdata_o, 0);
        chk("to_late_err", mem_err_o, 1);
        clr_in();
        step();

        // Response carrying a bus error.
        set_load(64'h80);
        step();
        dmem_req_ready_i = 1;
        step();
        dmem_req_ready_i = 0;
        dmem_rsp_valid_i = 1;
        dmem_rsp_err_i = 1;
        dmem_rsp_rdata_i = 64'h0000_0000_0000_1234;
        step();
        chk("be_done", mem_done_o, 1);
        chk("be_err", mem_err_o, 1);
        chk("be_rdata", mem_rdata_o, 64'h1234);
        clr_in();
        step();

        // Flush blocks the start.
        set_load(64'hC0);
        flush_i = 1;
        #1;
        chk("fl_stall", pipe_stall_o, 0);
        step();
        chk("fl_no_req", dmem_req_valid_o, 0);
        clr_in();
        step();

        // Reset in WAIT abandons the access; the next op runs cleanly.
        set_load(64'h100);
        step();
        dmem_req_ready_i = 1;
        step();
        dmem_req_ready_i = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        clr_in();
        #1;
        chk("rw_req_valid", dmem_req_valid_o, 0);
        chk("rw_stall", pipe_stall_o, 0);
        chk("rw_done", mem_done_o, 0);
        step();
        set_load(64'h140);
        step();
        chk("rw_next_req", dmem_req_valid_o, 1);
        dmem_req_ready_i = 1;
        step();
        dmem_req_ready_i = 0;
        dmem_rsp_valid_i = 1;
        dmem_rsp_rdata_i = 64'h5555_6666_7777_8888;
        step();
        chk("rw_next_done", mem_done_o, 1);
        chk("rw_next_rdata", mem_rdata_o, 64'h5555_6666_7777_8888);
        clr_in();
        step();

        // Back-to-back loads with the bus always ready and responding.
        done1 = -1;
        req2 = -1;
        set_load(64'h200);
        dmem_req_ready_i = 1;
        dmem_rsp_valid_i = 1;
        for (int i = 0; i < 12; i++) begin
            if (mem_done_o && done1 < 0) done1 = cyc;
            else if (done1 >= 0 && dmem_req_valid_o && req2 < 0) req2 = cyc;
            dmem_rsp_rdata_i = {$urandom, $urandom};
            step();
        end
        chk("b2b_req_gap", 64'(req2 - done1), 64'd2);
        clr_in();
        step();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            kind = int'($urandom_range(0, 3));
            mem_op_valid_i   = (kind != 0);
            mem_is_load_i    = (kind == 1);
            mem_is_store_i   = (kind == 2);
            flush_i          = ($urandom_range(0, 5) == 0);
            mem_addr_i       = {$urandom, $urandom};
            mem_wdata_i      = {$urandom, $urandom};
            mem_wmask_i      = 8'($urandom);
            dmem_req_ready_i = ($urandom_range(0, 2) == 0);
            dmem_rsp_valid_i = ($urandom_range(0, 7) == 0);
            dmem_rsp_rdata_i = {$urandom, $urandom};
            dmem_rsp_err_i   = ($urandom_range(0, 4) == 0);
            step();
        end
        rst = 0;
        clr_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
